// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings for the bit-serial ALU sequencer
// Purpose: FSM state encoding, arithmetic op codes and the op-field bit
//          index that selects arithmetic mode.
// Ports:   none (package).
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // op[ARIT_BIT]=1 selects the adder path; op[0] then picks SUB over ADD.
  localparam int         ARIT_BIT = 2;
  localparam logic [2:0] OP_ADD   = 3'b100;
  localparam logic [2:0] OP_SUB   = 3'b101;

endpackage

// File: rtl/shreg_r.sv
// rtl/shreg_r.sv - WIDTH-bit right-shift register with parallel load
// Purpose: holds an operand or the collected result; load has priority
//          over shift, and shifting pulls sin_i into the MSB.
// Ports:   clk, reset (sync, active-high)
//          load_i, d_i   parallel load
//          shift_i, sin_i right shift with serial input
//          q_o           register contents (q_o[0] is the next bit out)
module shreg_r #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= d_i;
    end else if (shift_i) begin
      q_q <= {sin_i, q_q[WIDTH-1:1]};
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/serial_alu_ctrl.sv
// rtl/serial_alu_ctrl.sv - bit-serial sequencer around a 1-bit ALU slice
// Purpose: feeds operands LSB-first to an external 1-bit slice, loops the
//          slice carry back, collects result bits and produces Z/C/V flags.
// Ports:   clk, reset (sync, active-high)
//          start, op[2:0], opa, opb   request side; ready high in IDLE
//          done, result, flag_z/c/v   completion side; done is a 1-cycle pulse
//          slice_a/b/cin/arit/s       drive to slice (0 outside RUN)
//          slice_out, slice_cout      combinational return from slice
//          abort                      only when SERIAL_ALU_ABORT_EN is defined
import alu_pkg::*;

module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
`ifdef SERIAL_ALU_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic             slice_arit,
  output logic [1:0]       slice_s,
  input  logic             slice_out,
  input  logic             slice_cout
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q;
  logic             carry_q, prev_c_q;
  logic [WIDTH-1:0] result_q;
  logic             flag_z_q, flag_c_q, flag_v_q, done_q;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;

  logic accept, running, shift_en, abort_run, sub;

  assign accept  = (state_q == IDLE) && start;
  assign running = (state_q == RUN);
  assign sub     = op_q[ARIT_BIT] & op_q[0];

`ifdef SERIAL_ALU_ABORT_EN
  assign abort_run = running & abort;
`else
  assign abort_run = 1'b0;
`endif

  assign shift_en = running & ~abort_run;

  shreg_r #(.WIDTH(WIDTH)) u_a_sh (
    .clk(clk), .reset(reset), .load_i(accept), .shift_i(shift_en),
    .d_i(opa), .sin_i(1'b0), .q_o(a_sh)
  );

  shreg_r #(.WIDTH(WIDTH)) u_b_sh (
    .clk(clk), .reset(reset), .load_i(accept), .shift_i(shift_en),
    .d_i(opb), .sin_i(1'b0), .q_o(b_sh)
  );

  // Result register is cleared on accept so a fresh word is collected.
  shreg_r #(.WIDTH(WIDTH)) u_res_sh (
    .clk(clk), .reset(reset), .load_i(accept), .shift_i(shift_en),
    .d_i('0), .sin_i(slice_out), .q_o(res_sh)
  );

  // Only bit 0 of the operand registers reaches the slice.
  logic unused_sh;
  assign unused_sh = ^{a_sh[WIDTH-1:1], b_sh[WIDTH-1:1]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    slice_a    = 1'b0;
    slice_b    = 1'b0;
    slice_cin  = 1'b0;
    slice_arit = 1'b0;
    slice_s    = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        slice_a    = a_sh[0];
        slice_b    = b_sh[0] ^ sub;   // SUB feeds ~B; the +1 comes via carry
        slice_cin  = carry_q;
        slice_arit = op_q[ARIT_BIT];
        slice_s    = op_q[1:0];
        if (abort_run) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      prev_c_q <= 1'b0;
      result_q <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_v_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= 1'b0;
      if (accept) begin
        op_q     <= op;
        carry_q  <= op[ARIT_BIT] & op[0];
        prev_c_q <= 1'b0;
      end
      if (shift_en) begin
        // prev_c ends up as the carry into the MSB, needed for overflow.
        prev_c_q <= carry_q;
        carry_q  <= slice_cout;
      end
      // Result, flags and done are registered together so done marks valid data.
      if (state_q == DONE) begin
        result_q <= res_sh;
        flag_z_q <= (res_sh == '0);
        flag_c_q <= op_q[ARIT_BIT] & carry_q;
        flag_v_q <= op_q[ARIT_BIT] & (prev_c_q ^ carry_q);
        done_q   <= 1'b1;
      end
    end
  end

  assign ready  = (state_q == IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
  assign flag_v = flag_v_q;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb/tb_serial_alu_ctrl.sv - directed self-checking bench for serial_alu_ctrl
import alu_pkg::*;

module tb_serial_alu_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         abort;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] opa, opb;
  logic         ready, done, flag_z, flag_c, flag_v;
  logic [W-1:0] result;
  logic         slice_a, slice_b, slice_cin, slice_arit, slice_out, slice_cout;
  logic [1:0]   slice_s;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
`ifdef SERIAL_ALU_ABORT_EN
    .abort(abort),
`endif
    .start(start),
    .op(op),
    .opa(opa),
    .opb(opb),
    .ready(ready),
    .done(done),
    .result(result),
    .flag_z(flag_z),
    .flag_c(flag_c),
    .flag_v(flag_v),
    .slice_a(slice_a),
    .slice_b(slice_b),
    .slice_cin(slice_cin),
    .slice_arit(slice_arit),
    .slice_s(slice_s),
    .slice_out(slice_out),
    .slice_cout(slice_cout)
  );

  // Golden 1-bit slice: s=00 AND, 01 OR, 10 XOR, 11 NOR; arit selects the adder.
  logic slice_logic, slice_sum;
  always_comb begin
    slice_logic = 1'b0;
    case (slice_s)
      2'b00: slice_logic = slice_a & slice_b;
      2'b01: slice_logic = slice_a | slice_b;
      2'b10: slice_logic = slice_a ^ slice_b;
      default: slice_logic = ~(slice_a | slice_b);
    endcase
    slice_sum  = slice_a ^ slice_b ^ slice_cin;
    slice_cout = (slice_a & slice_b) | (slice_cin & (slice_a ^ slice_b));
    slice_out  = slice_arit ? slice_sum : slice_logic;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one op; operands are scrambled after acceptance to show they are not re-sampled.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] er,
                       input logic ez, input logic ec, input logic ev);
    int k;
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); opa = W'($urandom); opb = W'($urandom);
    k = 0;
    while (!done && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, " latency"}, k, 9);
    chk({tag, " result"}, result, er);
    chk({tag, " flags"}, {flag_z, flag_c, flag_v}, {ez, ec, ev});
    chk({tag, " ready"}, ready, 1'b1);
    @(posedge clk); #1;
    chk({tag, " done width"}, done, 1'b0);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
  endtask

  int nd;

  initial begin
    reset = 1'b1; abort = 1'b0; start = 1'b0; op = '0; opa = '0; opb = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset ready", ready, 1'b1);
    chk("reset done", done, 1'b0);
    chk("reset result", result, 8'h00);
    chk("reset flags", {flag_z, flag_c, flag_v}, 3'b000);
    chk("reset slice", {slice_a, slice_b, slice_cin, slice_arit, slice_s}, 6'b0);

    do_op("add 7f+01", OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
    do_op("sub 05-05", OP_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0);
    do_op("sub 00-01", OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
    do_op("add ff+01", OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
    do_op("sub 80-01", OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1);
    do_op("and", 3'b000, 8'hA5, 8'h3C, 8'h24, 1'b0, 1'b0, 1'b0);
    do_op("or",  3'b001, 8'hA5, 8'h3C, 8'hBD, 1'b0, 1'b0, 1'b0);
    do_op("xor", 3'b010, 8'hA5, 8'h3C, 8'h99, 1'b0, 1'b0, 1'b0);
    do_op("nor", 3'b011, 8'hA5, 8'h3C, 8'h42, 1'b0, 1'b0, 1'b0);
    do_op("and ff", 3'b000, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);

    chk("idle slice", {slice_a, slice_b, slice_cin, slice_arit, slice_s}, 6'b0);

    // start held high through RUN and DONE: only the first request counts.
    start = 1'b1; op = OP_ADD; opa = 8'h12; opb = 8'h34;
    @(posedge clk); #1;
    opa = 8'h00; opb = 8'h00; op = OP_SUB;
    nd = 0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 1) chk("busy ready run", ready, 1'b0);
      if (k == 8) chk("busy ready done", ready, 1'b0);
      if (done) nd++;
    end
    start = 1'b0;
    chk("busy ready after", ready, 1'b1);
    chk("busy result", result, 8'h46);
    count_dones(14, nd);
    chk("busy extra done", nd, 0);

    // Reset mid-run at cnt=4 discards the op.
    start = 1'b1; op = OP_ADD; opa = 8'h01; opb = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst ready", ready, 1'b1);
    chk("rst result", result, 8'h00);
    chk("rst flags", {flag_z, flag_c, flag_v}, 3'b000);
    count_dones(12, nd);
    chk("rst no done", nd, 0);
    do_op("after rst", OP_ADD, 8'h20, 8'h22, 8'h42, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_ALU_ABORT_EN
    do_op("pre abort", OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
    start = 1'b1; op = OP_SUB; opa = 8'h05; opb = 8'h05;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort ready", ready, 1'b1);
    chk("abort result", result, 8'h80);
    chk("abort flags", {flag_z, flag_c, flag_v}, 3'b001);
    count_dones(12, nd);
    chk("abort no done", nd, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
